// File: rtl/stego_pkg.sv
// Shared constants and FSM encoding for the stego frame builder and LSB embedder.
package stego_pkg;

   localparam int unsigned FRAME_SIZE_DEF = 8;
   localparam int unsigned BPS_DEF        = 16;
   localparam int unsigned FRAME_CNT_W    = 16;

   typedef enum logic [1:0] {
      StCollect = 2'd0,
      StWaitMsg = 2'd1,
      StPresent = 2'd2
   } state_e;

   // Sample counter width; a one-sample frame still needs a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned frame_size);
      int unsigned w;
      w = $clog2(frame_size);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/stego_frame_builder_if.sv
// Sample stream, message port and assembled-frame output of the stego frame builder.
interface stego_frame_builder_if #(
   parameter int unsigned FRAME_SIZE = stego_pkg::FRAME_SIZE_DEF,
   parameter int unsigned BPS        = stego_pkg::BPS_DEF
) ();

   logic [BPS-1:0]            in_sample;
   logic                      in_valid;
   logic                      in_ready;
   logic [FRAME_SIZE-1:0]     in_msg;
   logic                      in_msg_valid;
   logic                      in_msg_ready;
   logic [FRAME_SIZE*BPS-1:0] out_frame;
   logic [FRAME_SIZE-1:0]     out_message;
   logic                      out_valid;
   logic                      out_ready;

   // Builder side.
   modport slave (
      input  in_sample, in_valid, in_msg, in_msg_valid, out_ready,
      output in_ready, in_msg_ready, out_frame, out_message, out_valid
   );

   // Producer/consumer side.
   modport master (
      output in_sample, in_valid, in_msg, in_msg_valid, out_ready,
      input  in_ready, in_msg_ready, out_frame, out_message, out_valid
   );

endinterface

// File: rtl/stego_frame_builder.sv
// Collects FRAME_SIZE samples plus one message word and presents them as a parallel frame.
// Optional frame counter output enabled by defining STEGO_FRAME_CNT_EN.
module stego_frame_builder
   import stego_pkg::*;
#(
   parameter int unsigned FRAME_SIZE = FRAME_SIZE_DEF,
   parameter int unsigned BPS        = BPS_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
`ifdef STEGO_FRAME_CNT_EN
   stego_frame_builder_if.slave   bus,
   output logic [FRAME_CNT_W-1:0] frame_cnt
`else
   stego_frame_builder_if.slave   bus
`endif
);

   localparam int unsigned CntW = cnt_width(FRAME_SIZE);
   localparam logic [CntW-1:0] LastIdx = CntW'(FRAME_SIZE - 1);

   state_e                    state_q, state_d;
   logic [CntW-1:0]           cnt_q, cnt_d;
   logic                      msg_full_q, msg_full_d;
   logic [FRAME_SIZE*BPS-1:0] frame_q, frame_d;
   logic [FRAME_SIZE-1:0]     message_q, message_d;

   logic in_ready, msg_ready, out_valid;
   logic sample_acc, msg_acc, out_acc;

   // Ready signals depend only on state, never on the same port's valid.
   always_comb begin
      in_ready   = (state_q == StCollect);
      msg_ready  = !msg_full_q;
      out_valid  = (state_q == StPresent);
      sample_acc = bus.in_valid && in_ready;
      msg_acc    = bus.in_msg_valid && msg_ready;
      out_acc    = out_valid && bus.out_ready;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      msg_full_d = msg_full_q;
      frame_d    = frame_q;
      message_d  = message_q;

      if (msg_acc) begin
         message_d  = bus.in_msg;
         msg_full_d = 1'b1;
      end

      case (state_q)
         StCollect: begin
            if (sample_acc) begin
               frame_d[cnt_q*BPS +: BPS] = bus.in_sample;
               if (cnt_q == LastIdx) begin
                  cnt_d   = '0;
                  state_d = (msg_full_q || msg_acc) ? StPresent : StWaitMsg;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StWaitMsg: begin
            if (msg_acc) begin
               state_d = StPresent;
            end
         end
         StPresent: begin
            // The frame is left in place and overwritten by the next collection.
            if (out_acc) begin
               state_d    = StCollect;
               msg_full_d = 1'b0;
            end
         end
         default: begin
            state_d = StCollect;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StCollect;
         cnt_q      <= '0;
         msg_full_q <= 1'b0;
         frame_q    <= '0;
         message_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         msg_full_q <= msg_full_d;
         frame_q    <= frame_d;
         message_q  <= message_d;
      end
   end

   assign bus.in_ready     = in_ready;
   assign bus.in_msg_ready = msg_ready;
   assign bus.out_valid    = out_valid;
   assign bus.out_frame    = frame_q;
   assign bus.out_message  = message_q;

`ifdef STEGO_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] frame_cnt_q;

   // Wraps naturally at 16'hFFFF.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= '0;
      end else if (out_acc) begin
         frame_cnt_q <= frame_cnt_q + 1'b1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_stego_frame_builder.sv
// Directed self-checking bench for stego_frame_builder (FRAME_SIZE=8, BPS=16).
module tb_stego_frame_builder;

   localparam int unsigned FS  = 8;
   localparam int unsigned BPS = 16;

   logic clk;
   logic rst_n;
   int   checks;
   int   fails;
   logic [FS*BPS-1:0] exp_frame;

   stego_frame_builder_if #(.FRAME_SIZE(FS), .BPS(BPS)) bus ();

`ifdef STEGO_FRAME_CNT_EN
   logic [15:0] frame_cnt;
   stego_frame_builder #(.FRAME_SIZE(FS), .BPS(BPS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .frame_cnt (frame_cnt)
   );
`else
   stego_frame_builder #(.FRAME_SIZE(FS), .BPS(BPS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst_n            = 1'b0;
      bus.in_sample    = '0;
      bus.in_valid     = 1'b0;
      bus.in_msg       = '0;
      bus.in_msg_valid = 1'b0;
      bus.out_ready    = 1'b1;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      chk("rst_in_ready", bus.in_ready, 1);
      chk("rst_msg_ready", bus.in_msg_ready, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_frame", bus.out_frame, 0);
      chk("rst_out_message", bus.out_message, 0);
`ifdef STEGO_FRAME_CNT_EN
      chk("rst_frame_cnt", frame_cnt, 0);
`endif

      // 1: message first, then eight samples back-to-back
      bus.in_msg = 8'hA5;
      bus.in_msg_valid = 1'b1;
      tick();
      bus.in_msg_valid = 1'b0;
      chk("t1_msg_ready_low", bus.in_msg_ready, 0);
      for (int i = 0; i < 8; i++) begin
         bus.in_sample = 16'h1000 + 16'(i);
         bus.in_valid  = 1'b1;
         chk("t1_no_valid_early", bus.out_valid, 0);
         tick();
      end
      bus.in_valid = 1'b0;
      chk("t1_out_valid", bus.out_valid, 1);
      chk("t1_in_ready_low", bus.in_ready, 0);
      chk("t1_frame_lo", bus.out_frame[15:0], 16'h1000);
      chk("t1_frame_hi", bus.out_frame[127:112], 16'h1007);
      chk("t1_message", bus.out_message, 8'hA5);
      tick();
      chk("t1_valid_one_cycle", bus.out_valid, 0);
      chk("t1_in_ready_back", bus.in_ready, 1);
      chk("t1_msg_ready_back", bus.in_msg_ready, 1);

      // 2: samples first, message five cycles later
      for (int i = 0; i < 8; i++) begin
         bus.in_sample = 16'h2000 + 16'(i);
         bus.in_valid  = 1'b1;
         tick();
      end
      bus.in_sample = 16'hBEEF;
      for (int i = 0; i < 4; i++) begin
         chk("t2_wait_in_ready", bus.in_ready, 0);
         chk("t2_wait_no_valid", bus.out_valid, 0);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_msg = 8'h3C;
      bus.in_msg_valid = 1'b1;
      tick();
      bus.in_msg_valid = 1'b0;
      chk("t2_out_valid", bus.out_valid, 1);
      chk("t2_message", bus.out_message, 8'h3C);
      chk("t2_frame_s3", bus.out_frame[63:48], 16'h2003);
      chk("t2_frame_s7", bus.out_frame[127:112], 16'h2007);
      tick();
      chk("t2_valid_drop", bus.out_valid, 0);

      // 3: message and last sample on the same edge; 4: then stall six cycles
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.in_sample = 16'h3000 + 16'(i * 16'h11);
         exp_frame[i*BPS +: BPS] = 16'h3000 + 16'(i * 16'h11);
         bus.in_valid = 1'b1;
         if (i == 7) begin
            bus.in_msg = 8'h5A;
            bus.in_msg_valid = 1'b1;
            chk("t3_still_collect", bus.in_ready, 1);
         end
         tick();
      end
      bus.in_sample = 16'hDEAD;
      bus.in_msg = 8'hFF;
      chk("t3_out_valid", bus.out_valid, 1);
      chk("t3_message", bus.out_message, 8'h5A);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t4_hold_valid", bus.out_valid, 1);
         chk("t4_hold_frame", bus.out_frame, exp_frame);
         chk("t4_hold_message", bus.out_message, 8'h5A);
         chk("t4_in_ready_low", bus.in_ready, 0);
         chk("t4_msg_ready_low", bus.in_msg_ready, 0);
      end
      bus.in_valid = 1'b0;
      bus.in_msg_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("t4_released", bus.out_valid, 0);
      chk("t4_msg_not_taken", bus.in_msg_ready, 1);
`ifdef STEGO_FRAME_CNT_EN
      chk("t6_frame_cnt_3", frame_cnt, 3);
`endif

      // 5: reset after three samples
      for (int i = 0; i < 3; i++) begin
         bus.in_sample = 16'h4000 + 16'(i);
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      #2;
      chk("t5_rst_valid", bus.out_valid, 0);
      chk("t5_rst_frame", bus.out_frame, 0);
      chk("t5_rst_in_ready", bus.in_ready, 1);
`ifdef STEGO_FRAME_CNT_EN
      chk("t5_rst_frame_cnt", frame_cnt, 0);
`endif
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_sample = 16'h5000 + 16'(i);
         exp_frame[i*BPS +: BPS] = 16'h5000 + 16'(i);
         bus.in_valid = 1'b1;
         bus.in_msg = 8'h77;
         bus.in_msg_valid = (i == 0);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.in_msg_valid = 1'b0;
      chk("t5_out_valid", bus.out_valid, 1);
      chk("t5_clean_frame", bus.out_frame, exp_frame);
      chk("t5_message", bus.out_message, 8'h77);
      tick();
      chk("t5_done", bus.out_valid, 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
